led_pattern_engine: RTL
=======================

Name: led_pattern_engine

Overview:
- Parametrised LED pattern generator for the board LED bank, replacing the fixed 8-bit left/right/bounce shifters.
- Contains an internal clock divider that produces a step pulse, so it runs directly from the 50 MHz board clock.
- Implements selectable modes: hold, rotate right, rotate left, bounce, fill/clear sweep and converge-to-middle.
- Supports synchronous load, zero-pattern self-seeding and a step-pulse output for downstream counters or the LED7 display.

Parameters:
- WIDTH, 8: LED/pattern width. Must be even and >= 4.
- DIV, 25_000_000: CLK cycles per pattern step. Must be >= 1; DIV=1 steps every cycle. The default gives 2 steps/s at 50 MHz.

Ports:
- CLK, in, 1: system clock; all state updates on posedge.
- RST, in, 1: reset, asynchronous, active-low. Q, dir, cnt and tick clear immediately while RST=0.
- en, in, 1: pattern advance enable; the divider runs regardless.
- mode, in, 3: 0 hold, 1 rotate right, 2 rotate left, 3 bounce, 4 fill sweep, 5 converge. 6 and 7 behave as hold.
- load, in, 1: synchronous load strobe.
- load_data, in, WIDTH: value written to Q on load.
- Q, out, WIDTH: LED pattern (registered).
- tick, out, 1: registered one-cycle pulse, high in the cycle the new Q (from a step) is first visible.
- dir, out, 1: bounce direction. 0 = moving toward LSB, 1 = moving toward MSB.

Behaviour:
- Reset values: Q=0, dir=0, tick=0, divider counter cnt=0.
- Divider:
  - cnt width is $clog2(DIV), minimum 1.
  - step = (cnt == DIV-1). On step, cnt <= 0; otherwise cnt <= cnt+1.
  - The divider is free-running; en does not affect it.
  - tick <= step each cycle, so tick is high once per DIV cycles.
- Priority per posedge: load, then (step & en), then hold.
- Load:
  - Q <= load_data, dir <= 0, cnt <= 0, tick <= 0.
  - Load wins over a coincident step; that step is discarded.
- On step & en, with Q==0, seeding applies (only modes 1, 2, 3, 5):
  - modes 1 and 3: Q <= 1 at MSB only (e.g. 8'h80).
  - mode 2: Q <= 1 at LSB only (8'h01).
  - mode 5: Q <= MSB|LSB (8'h81).
  - The seed consumes the step.
- On step & en otherwise:
  - mode 1: Q <= {Q[0], Q[W-1:1]}.
  - mode 2: Q <= {Q[W-2:0], Q[W-1]}.
  - mode 3:
    - If dir=0 and Q[0]=1: dir <= 1, Q <= Q<<1.
    - Else if dir=1 and Q[W-1]=1: dir <= 0, Q <= Q>>1.
    - Else Q shifts logically (zero fill) in direction dir: dir=0 gives Q>>1, dir=1 gives Q<<1.
    - The endpoint is not repeated; the one-hot period is 2*(W-1) steps.
  - mode 4: Q <= {~Q[0], Q[W-1:1]}. Q==0 is a legal start (no seeding); period is 2*W steps.
  - mode 5:
    - Upper half rotates right: Q[W-1:W/2] <= {Q[W/2], Q[W-1:W/2+1]}.
    - Lower half rotates left: Q[W/2-1:0] <= {Q[W/2-2:0], Q[W/2-1]}.
  - modes 0, 6, 7: Q and dir unchanged.
- Mode changes:
  - Take effect on the next step.
  - dir persists across mode changes and is only updated in mode 3, by load, or by reset.
- en=0: Q and dir frozen; tick keeps pulsing.
- RST asserted mid-operation clears all state asynchronously. After RST deasserts, the first step occurs DIV cycles later.

Test Plan (WIDTH=8, DIV=4 unless noted):
1. Reset, then en=1, mode=1 → first tick 4 cycles after RST release with Q=80; following steps give 40, 20, …, 01, then 80 (wrap). tick width is 1 cycle, period 4.
2. load_data=02, load, mode=3 → Q=01 (dir=0), 02 (dir=1), 04, …, 80, 40 (dir=0). Period 14 steps; no duplicated endpoint.
3. Start from Q=00, mode=4 → 80, C0, E0, F0, F8, FC, FE, FF, 7F, 3F, …, 01, 00. Period 16.
4. Start from Q=00, mode=5 → seed 81, then 42, 24, 18, 81. Separately, load=1 in the same cycle as a step with load_data=A5 → Q=A5, cnt=0, next tick 4 cycles later.
5. mode=2 running, en=0 for 10 cycles → Q frozen and tick continues. Then assert RST low mid-count → Q=0, dir=0, tick=0 immediately, without waiting for CLK.
6. DIV=1, mode=2, from Q=00 → Q=01, 02, 04, … on consecutive cycles; tick is constantly 1 after the first cycle.

Source files
------------

// File: rtl/led_pattern_engine.sv
// LED pattern generator for the board LED bank: free-running step divider plus
// hold / rotate / bounce / fill-sweep / converge pattern modes with load and self-seeding.
module led_pattern_engine #(
  parameter int WIDTH = 8,
  parameter int DIV   = 25_000_000
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] Q,
  output logic             tick,
  output logic             dir
);

  localparam int CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int HALF = WIDTH / 2;

  localparam logic [CW-1:0]    CNT_LAST = CW'(DIV - 1);
  localparam logic [WIDTH-1:0] MSB_ONLY = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] LSB_ONLY = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    MODE_HOLD     = 3'd0,
    MODE_ROR      = 3'd1,
    MODE_ROL      = 3'd2,
    MODE_BOUNCE   = 3'd3,
    MODE_FILL     = 3'd4,
    MODE_CONVERGE = 3'd5,
    MODE_RSVD6    = 3'd6,
    MODE_RSVD7    = 3'd7
  } mode_t;

  logic [CW-1:0]    cnt;
  logic             step;
  logic [WIDTH-1:0] next_q;
  logic             next_dir;
  logic             q_zero;

  assign step   = (cnt == CNT_LAST);
  assign q_zero = (Q == '0);

  // Next pattern for a step; an all-zero Q seeds instead of advancing (except fill sweep).
  always_comb begin
    next_q   = Q;
    next_dir = dir;
    case (mode_t'(mode))
      MODE_ROR: begin
        if (q_zero) next_q = MSB_ONLY;
        else        next_q = {Q[0], Q[WIDTH-1:1]};
      end
      MODE_ROL: begin
        if (q_zero) next_q = LSB_ONLY;
        else        next_q = {Q[WIDTH-2:0], Q[WIDTH-1]};
      end
      MODE_BOUNCE: begin
        if (q_zero) begin
          next_q = MSB_ONLY;
        end else if (!dir && Q[0]) begin
          next_dir = 1'b1;
          next_q   = Q << 1;
        end else if (dir && Q[WIDTH-1]) begin
          next_dir = 1'b0;
          next_q   = Q >> 1;
        end else begin
          next_q = dir ? (Q << 1) : (Q >> 1);
        end
      end
      MODE_FILL: begin
        next_q = {~Q[0], Q[WIDTH-1:1]};
      end
      MODE_CONVERGE: begin
        if (q_zero) begin
          next_q = MSB_ONLY | LSB_ONLY;
        end else begin
          next_q[WIDTH-1:HALF] = {Q[HALF], Q[WIDTH-1:HALF+1]};
          next_q[HALF-1:0]     = {Q[HALF-2:0], Q[HALF-1]};
        end
      end
      default: begin
        next_q   = Q;
        next_dir = dir;
      end
    endcase
  end

  // Load beats a coincident step and restarts the divider so the next step is DIV cycles away.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      Q    <= '0;
      dir  <= 1'b0;
      tick <= 1'b0;
      cnt  <= '0;
    end else if (load) begin
      Q    <= load_data;
      dir  <= 1'b0;
      tick <= 1'b0;
      cnt  <= '0;
    end else begin
      cnt  <= step ? '0 : cnt + 1'b1;
      tick <= step;
      if (step && en) begin
        Q   <= next_q;
        dir <= next_dir;
      end
    end
  end

endmodule
